pipe_adder: RTL
===============

Name: pipe_adder

Overview:
Parametrised, pipelined integer adder/subtractor for the CPU datapath; successor to the single-cycle 32-bit adder.
- Splits a WIDTH-bit operation into STAGES carry-chained chunks, one chunk per pipeline stage.
- Accepts one operation per cycle under a valid/ready handshake.
- Produces result, raw carry-out, signed overflow (double-sign-bit method) and zero flag.
- Sits between the decode/operand stage and the ALU result mux; long-carry paths no longer limit clock frequency.

Parameters:
WIDTH, 32, operand/result width in bits (>=2).
STAGES, 4, pipeline depth and chunk count (>=1; must divide WIDTH; elaboration error otherwise).
CHUNK, WIDTH/STAGES, derived chunk width (localparam, not overridable).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operation offered.
in_ready  out  1  pipeline can accept this cycle.
operand1  in  WIDTH  first operand.
operand2  in  WIDTH  second operand.
cin  in  1  carry-in (add) / borrow-in (sub).
sub  in  1  0: op1+op2+cin; 1: op1-op2-cin.
out_valid  out  1  result presented.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  sum/difference modulo 2^WIDTH.
cout  out  1  raw adder carry-out of MSB (sub: 1 = no borrow).
overflow  out  1  signed overflow.
zero  out  1  result == 0.

Behaviour:
- Reset is asynchronous, active-high. While rst=1: every stage valid bit is 0, all stage data registers are 0, out_valid=0, result=0, cout=0, overflow=0, zero=0.
- Reset mid-operation drops all in-flight operations; no output appears after release.
- in_ready is 1 in the first cycle after reset release.
- Operand conditioning:
  - op2' = sub ? ~operand2 : operand2.
  - c0 = sub ? ~cin : cin.
  - The adder computes operand1 + op2' + c0.
- Stage k (0..STAGES-1) adds chunk k of op1 and op2', using the carry registered by stage k-1 (c0 for k=0).
- Stage k registers:
  - result chunks 0..k;
  - the not-yet-used operand chunks k+1..;
  - the chunk carry;
  - a running zero AND of the chunks computed so far.
- Final stage:
  - Sign-extends its top chunk by one bit on both operands (double sign bit).
  - overflow = s[WIDTH] XOR s[WIDTH-1].
  - cout = carry out of bit WIDTH-1 of the unextended sum.
- Latency: an op accepted at edge t (in_valid & in_ready) drives out_valid=1 from edge t+STAGES onward. Throughput is 1 op/cycle when out_ready=1.
- Handshake:
  - Each stage advances when ready_k = ~valid_k | ready_{k+1}.
  - ready_STAGES = out_ready.
  - in_ready = ready_0 (combinational path from out_ready is permitted).
- Stall: while out_valid & ~out_ready, result/cout/overflow/zero/out_valid hold stable. Upstream bubbles are compressed; maximum occupancy is STAGES ops.
- Simultaneous accept at input and output in the same cycle is legal, and occupancy is unchanged.
- Ordering: results leave strictly in acceptance order; no drop, no duplicate.
- in_valid & ~in_ready: the input is ignored, and the producer holds it.
- STAGES=1: behaves as a registered single-cycle adder with latency 1.
- Wrap-around: the result is modulo 2^WIDTH; cout/overflow report the wrap.

Decomposition:
- Shared header holds ALU flag bit indices (FLAG_COUT, FLAG_OVF, FLAG_ZERO) and the default WIDTH/STAGES constants.
- One sub-module: chunk_adder, a combinational CHUNK-bit adder with carry-in, carry-out and a chunk-zero output; instantiated STAGES times by generate.
- Pipeline registers and handshake stay in pipe_adder.

Test Plan:
1. WIDTH=32, STAGES=4: add 0x7FFFFFFF+0x00000001, cin=0 -> result 0x80000000, overflow=1, cout=0, zero=0; out_valid exactly 4 cycles after acceptance.
2. sub 0x00000005-0x00000005, cin=0 -> result 0, zero=1, cout=1, overflow=0. Then sub 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow=1, cout=1. Then sub 0-1 -> 0xFFFFFFFF, cout=0.
3. Carry ripple:
   - add 0xFFFFFFFF+0x00000000, cin=1 -> result 0, cout=1, overflow=0, zero=1.
   - add 0x000000FF+0x00000001 -> 0x00000100, carry crossing chunk boundary.
4. Eight back-to-back random ops with out_ready=1 -> eight consecutive out_valid cycles, results in order, matching a reference model.
5. Hold out_ready=0 while driving in_valid=1 continuously -> exactly 4 ops accepted, then in_ready=0 and outputs held stable. Release out_ready -> all ops drain in order with no loss; in_ready returns the same cycle.
6. Assert rst asynchronously (mid-cycle) with 3 ops in flight -> out_valid and all outputs go 0 immediately. After release, no stale results appear; the first new op emerges after 4 cycles.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// =============================================================================
// pipe_adder_pkg : ALU flag bit layout and default adder geometry
// Revision 1.0
// =============================================================================
package pipe_adder_pkg;

   localparam int FLAG_COUT = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_ZERO = 2;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_STAGES = 4;

endpackage
`default_nettype wire

// File: rtl/pipe_adder_chunk_adder.sv
`default_nettype none
// =============================================================================
// chunk_adder : combinational CHUNK-bit adder with carry in/out and zero flag
// Revision 1.0
// =============================================================================
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             zero
);

   logic [CHUNK:0] w_full;

   assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign sum    = w_full[CHUNK-1:0];
   assign cout   = w_full[CHUNK];
   assign zero   = (w_full[CHUNK-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// =============================================================================
// pipe_adder : STAGES-deep carry-chained adder/subtractor, valid/ready handshake
// Revision 1.0
// =============================================================================
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int CHUNK = (STAGES > 0) ? (WIDTH / STAGES) : WIDTH;

   if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipe_adder: STAGES must be >= 1 and divide WIDTH (WIDTH >= 2)");
   end

   logic [WIDTH-1:0]  w_op2;
   logic              w_c0;
   logic [STAGES:0]   w_ready;
   logic [WIDTH-1:0]  w_d [STAGES];
   logic [WIDTH-1:0]  w_b [STAGES];
   logic [STAGES-1:0] w_v;
   logic [STAGES-1:0] w_c;
   logic [STAGES-1:0] w_z;
   logic              w_ovf;

   // Subtraction is op1 + ~op2 + ~borrow, so cout=1 means no borrow.
   assign w_op2 = sub ? ~operand2 : operand2;
   assign w_c0  = sub ? ~cin : cin;

   assign w_ready[STAGES] = out_ready;
   assign in_ready        = w_ready[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_d_in;
      logic [WIDTH-1:0] w_b_in;
      logic             w_v_in;
      logic             w_c_in;
      logic             w_z_in;
      logic [CHUNK-1:0] w_sum;
      logic             w_cout;
      logic             w_czero;
      logic [WIDTH-1:0] w_d_nx;
      logic [WIDTH-1:0] r_d;
      logic             r_v;
      logic             r_c;
      logic             r_z;

      if (k == 0) begin : g_head
         assign w_d_in = operand1;
         assign w_b_in = w_op2;
         assign w_v_in = in_valid;
         assign w_c_in = w_c0;
         assign w_z_in = 1'b1;
      end else begin : g_body
         assign w_d_in = w_d[k-1];
         assign w_b_in = w_b[k-1];
         assign w_v_in = w_v[k-1];
         assign w_c_in = w_c[k-1];
         assign w_z_in = w_z[k-1];
      end

      assign w_ready[k] = ~r_v | w_ready[k+1];

      chunk_adder #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a    (w_d_in[k*CHUNK +: CHUNK]),
         .b    (w_b_in[k*CHUNK +: CHUNK]),
         .cin  (w_c_in),
         .sum  (w_sum),
         .cout (w_cout),
         .zero (w_czero)
      );

      // Data word carries finished result chunks below and unused op1 chunks above.
      always_comb begin
         w_d_nx                     = w_d_in;
         w_d_nx[k*CHUNK +: CHUNK]   = w_sum;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_v <= 1'b0;
            r_d <= '0;
            r_c <= 1'b0;
            r_z <= 1'b0;
         end else if (w_ready[k]) begin
            r_v <= w_v_in;
            if (w_v_in) begin
               r_d <= w_d_nx;
               r_c <= w_cout;
               r_z <= w_z_in & w_czero;
            end
         end
      end

      assign w_v[k] = r_v;
      assign w_d[k] = r_d;
      assign w_c[k] = r_c;
      assign w_z[k] = r_z;

      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:0] r_b;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_b <= '0;
            end else if (w_ready[k] && w_v_in) begin
               r_b <= w_b_in;
            end
         end

         assign w_b[k] = r_b;
      end else begin : g_tail
         logic [CHUNK:0] w_ext;
         logic           r_ovf;

         // Double sign bit: the extra MSB disagrees with the MSB on signed overflow.
         assign w_ext = {w_d_in[WIDTH-1], w_d_in[WIDTH-1 -: CHUNK]}
                      + {w_b_in[WIDTH-1], w_b_in[WIDTH-1 -: CHUNK]}
                      + {{CHUNK{1'b0}}, w_c_in};

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (w_ready[k] && w_v_in) begin
               r_ovf <= w_ext[CHUNK] ^ w_ext[CHUNK-1];
            end
         end

         assign w_b[k] = '0;
         assign w_ovf  = r_ovf;
      end
   end

   assign out_valid = w_v[STAGES-1];
   assign result    = w_d[STAGES-1];
   assign cout      = w_c[STAGES-1];
   assign overflow  = w_ovf;
   assign zero      = w_z[STAGES-1];

endmodule
`default_nettype wire
